// File: rtl/serial_cmp_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_cmp_arbiter_if : request, comparator and response bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface serial_cmp_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             cmp_rst;
  logic             cmp_a;
  logic             cmp_b;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_gt;
  logic             rsp_eq;
  logic             rsp_lt;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  cmp_gt, cmp_eq, cmp_lt, rsp_ready,
    output req0_ready, req1_ready, cmp_rst, cmp_a, cmp_b,
    output rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output cmp_gt, cmp_eq, cmp_lt, rsp_ready,
    input  req0_ready, req1_ready, cmp_rst, cmp_a, cmp_b,
    input  rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_cmp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_cmp_arbiter : round-robin sharing of one bit-serial magnitude comparator
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_cmp_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             cmp_rst_q;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_gt_q, rsp_gt_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_err_q, rsp_err_d;

  logic             w_any;
  logic             w_grant;
  logic             w_onehot;
  logic             w_req0_ready;
  logic             w_req1_ready;

  always_comb begin
    w_any   = bus.req0_valid | bus.req1_valid;
    // On contention the requester that did not win last time gets the slot
    w_grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    w_onehot = (bus.cmp_gt ^ bus.cmp_eq ^ bus.cmp_lt) &
               ~(bus.cmp_gt & bus.cmp_eq & bus.cmp_lt);

    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_gt_d     = rsp_gt_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_lt_d     = rsp_lt_q;
    rsp_err_d    = rsp_err_q;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_any) begin
          w_req0_ready = ~w_grant;
          w_req1_ready = w_grant;
          a_sh_d       = w_grant ? bus.req1_a : bus.req0_a;
          b_sh_d       = w_grant ? bus.req1_b : bus.req0_b;
          rsp_id_d     = w_grant;
          last_grant_d = w_grant;
          state_d      = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        rsp_gt_d    = bus.cmp_gt;
        rsp_eq_d    = bus.cmp_eq;
        rsp_lt_d    = bus.cmp_lt;
        rsp_err_d   = ~w_onehot;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      cmp_rst_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
      rsp_eq_q     <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      // Registered so the comparator sees a glitch-free clear for the CLR cycle
      cmp_rst_q    <= (state_d == S_CLR);
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_gt_q     <= rsp_gt_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_lt_q     <= rsp_lt_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.cmp_rst    = cmp_rst_q;
  assign bus.cmp_a      = (state_q == S_SHIFT) & a_sh_q[0];
  assign bus.cmp_b      = (state_q == S_SHIFT) & b_sh_q[0];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_gt     = rsp_gt_q;
  assign bus.rsp_eq     = rsp_eq_q;
  assign bus.rsp_lt     = rsp_lt_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_cmp_arbiter : randomized bench with transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_cmp_arbiter;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_cmp_arbiter_if #(.WIDTH(WIDTH)) bus ();

  serial_cmp_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Moore bit-serial comparator: the last differing bit seen decides
  logic cm_gt, cm_eq, cm_lt;
  logic inj;
  always @(posedge clk or posedge bus.cmp_rst) begin
    if (bus.cmp_rst) begin
      cm_gt <= 1'b0; cm_eq <= 1'b1; cm_lt <= 1'b0;
    end else if (bus.cmp_a & ~bus.cmp_b) begin
      cm_gt <= 1'b1; cm_eq <= 1'b0; cm_lt <= 1'b0;
    end else if (~bus.cmp_a & bus.cmp_b) begin
      cm_gt <= 1'b0; cm_eq <= 1'b0; cm_lt <= 1'b1;
    end
  end
  assign bus.cmp_gt = inj ? 1'b1 : cm_gt;
  assign bus.cmp_eq = inj ? 1'b1 : cm_eq;
  assign bus.cmp_lt = inj ? 1'b0 : cm_lt;

  int n_pass, n_chk;

  // Reference model: phase 0 idle, 1 job in flight (m_cnt = edges since accept), 2 response
  int               m_phase, m_cnt;
  logic             m_last, m_cmprst_init;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_id, m_gt, m_eq, m_lt, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_last = 1'b1; m_cmprst_init = 1'b1;
    m_a = '0; m_b = '0;
    m_id = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
  endtask

  function automatic logic model_grant();
    if (bus.req0_valid && bus.req1_valid) return ~m_last;
    return bus.req1_valid;
  endfunction

  task automatic compare_all();
    logic any, g, e_ca, e_cb;
    any = bus.req0_valid | bus.req1_valid;
    g   = model_grant();
    e_ca = 1'b0; e_cb = 1'b0;
    if (m_phase == 1 && m_cnt >= 2 && m_cnt <= WIDTH + 1) begin
      e_ca = m_a[m_cnt-2];
      e_cb = m_b[m_cnt-2];
    end
    chk("req0_ready", bus.req0_ready, (m_phase == 0) && any && !g);
    chk("req1_ready", bus.req1_ready, (m_phase == 0) && any && g);
    chk("cmp_rst", bus.cmp_rst, m_cmprst_init || (m_phase == 1 && m_cnt == 1));
    chk("cmp_a", bus.cmp_a, e_ca);
    chk("cmp_b", bus.cmp_b, e_cb);
    chk("rsp_valid", bus.rsp_valid, m_phase == 2);
    chk("rsp_id", bus.rsp_id, m_id);
    chk("rsp_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt, bus.rsp_err},
        {m_gt, m_eq, m_lt, m_err});
  endtask

  task automatic advance();
    logic g;
    if (reset) begin
      model_reset();
    end else begin
      g = model_grant();
      m_cmprst_init = 1'b0;
      case (m_phase)
        0: if (bus.req0_valid || bus.req1_valid) begin
             m_a = g ? bus.req1_a : bus.req0_a;
             m_b = g ? bus.req1_b : bus.req0_b;
             m_id = g; m_last = g; m_phase = 1; m_cnt = 1;
           end
        1: begin
             m_cnt++;
             if (m_cnt == WIDTH + 3) begin
               if (inj) begin
                 m_gt = 1; m_eq = 1; m_lt = 0; m_err = 1;
               end else begin
                 m_gt = m_a > m_b; m_eq = m_a == m_b; m_lt = m_a < m_b; m_err = 0;
               end
               m_phase = 2;
             end
           end
        default: if (bus.rsp_ready) m_phase = 0;
      endcase
    end
  endtask

  // Called just after a falling edge with inputs already set
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle_inputs();
    while (m_phase != 0 && n < 100) begin step(); n++; end
    chk("wait_idle_timeout", n < 100, 1);
  endtask

  task automatic directed(input string nm, input logic rq, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [3:0] exp_f);
    int lat;
    wait_idle();
    if (rq) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin step(); lat++; end
    chk({nm, "_latency"}, lat, WIDTH + 2);
    chk({nm, "_id"}, bus.rsp_id, rq);
    chk({nm, "_flags"}, {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt, bus.rsp_err}, exp_f);
    step();
  endtask

  initial begin
    n_pass = 0; n_chk = 0; inj = 0;
    reset = 1;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 0;
    model_reset();
    #2;
    chk("rst_cmp_rst", bus.cmp_rst, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_flags", {bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt, bus.rsp_err}, 0);
    @(negedge clk);
    step();
    reset = 0;
    step();

    // Basic results and MSB-decides cases
    directed("t1", 0, 8'h5A, 8'h3C, 4'b1000);
    directed("t2_msb", 0, 8'h80, 8'h7F, 4'b1000);
    directed("t2_lt", 0, 8'h01, 8'h80, 4'b0010);
    directed("t2_eq", 0, 8'hA5, 8'hA5, 4'b0100);

    // Alternation under constant contention, from a fresh reset
    begin
      int got, n;
      logic [3:0] ids, gts;
      wait_idle();
      reset = 1; model_reset(); step(); reset = 0;
      bus.req0_valid = 1; bus.req0_a = 8'h90; bus.req0_b = 8'h11;
      bus.req1_valid = 1; bus.req1_a = 8'h22; bus.req1_b = 8'hF0;
      bus.rsp_ready = 1;
      got = 0; n = 0; ids = '0; gts = '0;
      while (got < 4 && n < 200) begin
        step(); n++;
        if (bus.rsp_valid) begin
          ids[got] = bus.rsp_id; gts[got] = bus.rsp_gt; got++;
        end
      end
      chk("t3_count", got, 4);
      chk("t3_ids", ids, 4'b1010);
      chk("t3_gt_by_id", gts, 4'b0101);
    end

    // Back-pressure: response held while requests are pending
    begin
      int n;
      wait_idle();
      bus.req0_valid = 1; bus.req0_a = 8'h0F; bus.req0_b = 8'h0E; bus.rsp_ready = 0;
      step();
      n = 0;
      while (!bus.rsp_valid && n < 40) begin step(); n++; end
      bus.req0_valid = 1; bus.req1_valid = 1;
      for (int i = 0; i < 5; i++) step();
      chk("t4_still_valid", bus.rsp_valid, 1);
      chk("t4_held_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b100);
      idle_inputs();
      step();
    end

    // Reset in the middle of shifting
    wait_idle();
    bus.req0_valid = 1; bus.req0_a = 8'hC3; bus.req0_b = 8'h3C;
    step();
    bus.req0_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_mid_shift", m_cnt, 5);
    reset = 1;
    #1;
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_cmp_rst", bus.cmp_rst, 1);
    chk("t5_cmp_a", bus.cmp_a, 0);
    model_reset();
    @(negedge clk);
    step();
    reset = 0;
    directed("t5_after", 0, 8'h3C, 8'hC3, 4'b0010);

    // Comparator flags not one-hot
    wait_idle();
    inj = 1;
    directed("t6_err", 1, 8'h10, 8'h20, 4'b1101);
    wait_idle();
    inj = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_a = WIDTH'($urandom); bus.req0_b = WIDTH'($urandom);
      bus.req1_a = WIDTH'($urandom); bus.req1_b = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req0_b = bus.req0_a;
      if ($urandom_range(0, 3) == 0) bus.req1_b = bus.req1_a;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
